countdown_timer: RTL and testbench

Programmable countdown timer on the 200 MHz domain, the down-counting counterpart to the free-running sec/msec/usec timer. Accepts a duration in seconds/milliseconds/microseconds over a valid/ready handshake, counts it down in 1 µs steps, exposes the remaining time, and emits a one-cycle expiry pulse. Intended to drive timeouts and watchdogs in the same clock domain as the up-counting timer.

---
 rtl/countdown_timer.sv | 151 +++++++++++++++
 tb/tb_countdown_timer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Countdown timer: loads sec/ms/us over valid/ready, ticks 1 us per CLK_PER_US clocks, pulses expired; outputs registered, no load queuing.
// Optional COUNTDOWN_AUTO_RELOAD_EN: restart from the last loaded duration on every expiry (periodic mode).
module countdown_timer #(
  parameter int CLK_PER_US = 200
) (
  input  logic        clk_200mhz,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_sec,
  input  logic [15:0] load_msec,
  input  logic [15:0] load_usec,
  input  logic        cancel,
  output logic        busy,
  output logic        expired,
  output logic [31:0] rem_sec,
  output logic [15:0] rem_msec,
  output logic [15:0] rem_usec
);

  localparam int            PW           = $clog2(CLK_PER_US);
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLK_PER_US - 1);
  localparam logic [15:0]   SUB_MAX      = 16'd999;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [31:0]   sec_nxt;
  logic [15:0]   msec_nxt, usec_nxt;
  logic          busy_nxt, expired_nxt;

  logic [15:0]   msec_clamp, usec_clamp;
  logic          accept, load_zero, tick_last;
  logic [31:0]   dec_sec;
  logic [15:0]   dec_msec, dec_usec;

  assign load_ready = (state == IDLE) & ~reset;
  assign accept     = load_valid & load_ready;
  assign msec_clamp = (load_msec > SUB_MAX) ? SUB_MAX : load_msec;
  assign usec_clamp = (load_usec > SUB_MAX) ? SUB_MAX : load_usec;
  assign load_zero  = (load_sec == 32'd0) && (msec_clamp == 16'd0) && (usec_clamp == 16'd0);
  assign tick_last  = (rem_sec == 32'd0) && (rem_msec == 16'd0) && (rem_usec == 16'd1);

  // One microsecond off the remaining time, borrowing through msec into sec.
  always_comb begin
    dec_sec  = rem_sec;
    dec_msec = rem_msec;
    dec_usec = rem_usec;
    if (rem_usec != 16'd0) begin
      dec_usec = rem_usec - 16'd1;
    end else if (rem_msec != 16'd0) begin
      dec_usec = SUB_MAX;
      dec_msec = rem_msec - 16'd1;
    end else begin
      dec_usec = SUB_MAX;
      dec_msec = SUB_MAX;
      dec_sec  = rem_sec - 32'd1;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [31:0] rld_sec;
  logic [15:0] rld_msec, rld_usec;

  always_ff @(posedge clk_200mhz) begin
    if (reset) begin
      rld_sec  <= 32'd0;
      rld_msec <= 16'd0;
      rld_usec <= 16'd0;
    end else if (accept) begin
      rld_sec  <= load_sec;
      rld_msec <= msec_clamp;
      rld_usec <= usec_clamp;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    sec_nxt     = rem_sec;
    msec_nxt    = rem_msec;
    usec_nxt    = rem_usec;
    expired_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sec_nxt   = load_sec;
          msec_nxt  = msec_clamp;
          usec_nxt  = usec_clamp;
          presc_nxt = PRESC_RELOAD;
          if (load_zero) begin
            expired_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // Cancel takes priority over the final tick, so no expiry escapes.
        if (cancel) begin
          state_nxt = IDLE;
          presc_nxt = '0;
          sec_nxt   = 32'd0;
          msec_nxt  = 16'd0;
          usec_nxt  = 16'd0;
        end else if (presc != '0) begin
          presc_nxt = presc - PW'(1);
        end else begin
          presc_nxt = PRESC_RELOAD;
          sec_nxt   = dec_sec;
          msec_nxt  = dec_msec;
          usec_nxt  = dec_usec;
          if (tick_last) begin
            expired_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            sec_nxt  = rld_sec;
            msec_nxt = rld_msec;
            usec_nxt = rld_usec;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
    endcase
    busy_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk_200mhz) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      rem_sec  <= 32'd0;
      rem_msec <= 16'd0;
      rem_usec <= 16'd0;
      busy     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      rem_sec  <= sec_nxt;
      rem_msec <= msec_nxt;
      rem_usec <= usec_nxt;
      busy     <= busy_nxt;
      expired  <= expired_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (CLK_PER_US = 200); expiry cycles go through a scoreboard queue.
// Periodic-mode scenario is compiled in when COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_countdown_timer;

  logic        clk_200mhz = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_sec;
  logic [15:0] load_msec;
  logic [15:0] load_usec;
  logic        cancel;
  logic        busy;
  logic        expired;
  logic [31:0] rem_sec;
  logic [15:0] rem_msec;
  logic [15:0] rem_usec;

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int exp_cnt  = 0;
  int busy_cnt = 0;
  int popped   = 0;
  int exp_q[$];

  countdown_timer #(.CLK_PER_US(200)) dut (
    .clk_200mhz(clk_200mhz),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_sec  (load_sec),
    .load_msec (load_msec),
    .load_usec (load_usec),
    .cancel    (cancel),
    .busy      (busy),
    .expired   (expired),
    .rem_sec   (rem_sec),
    .rem_msec  (rem_msec),
    .rem_usec  (rem_usec)
  );

  always #5 clk_200mhz = ~clk_200mhz;

  always @(posedge clk_200mhz) cyc <= cyc + 1;

  always @(negedge clk_200mhz) begin
    if (expired === 1'b1) exp_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Drives one accepted load; returns with cyc == e0 (the cycle after the accept edge).
  task automatic do_load(input logic [31:0] s, input logic [15:0] m, input logic [15:0] u,
                         output int e0);
    @(negedge clk_200mhz);
    load_sec   = s;
    load_msec  = m;
    load_usec  = u;
    load_valid = 1'b1;
    e0 = cyc + 1;
    @(negedge clk_200mhz);
    load_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_200mhz);
  endtask

  task automatic wait_expired(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_200mhz);
      if (expired === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int e0;
    int base;
    reset = 1'b1; load_valid = 1'b0; cancel = 1'b0;
    load_sec = '0; load_msec = '0; load_usec = '0;
    repeat (3) @(negedge clk_200mhz);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready got=%b want=0", load_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL rst_expired got=%b want=0", expired); end
    checks++; if ({rem_sec, rem_msec, rem_usec} !== 64'd0) begin errors++;
      $display("FAIL rst_rem got=%0d/%0d/%0d want=0/0/0", rem_sec, rem_msec, rem_usec); end
    reset = 1'b0;
    @(negedge clk_200mhz);
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", load_ready); end
    // Reset in the middle of a countdown.
    do_load(32'd0, 16'd0, 16'd1, e0);
    wait_cyc(e0 + 100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    base = exp_cnt;
    reset = 1'b1;
    @(negedge clk_200mhz);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b want=0", load_ready); end
    checks++; if ({rem_sec, rem_msec, rem_usec} !== 64'd0) begin errors++;
      $display("FAIL midrst_rem got=%0d/%0d/%0d want=0/0/0", rem_sec, rem_msec, rem_usec); end
    reset = 1'b0;
    wait_cyc(cyc + 300);
    checks++; if (exp_cnt !== base) begin errors++; $display("FAIL midrst_no_expiry got=%0d want=%0d", exp_cnt, base); end
  endtask

  task automatic test_basic();
    int e0;
    int want;
    bit found;
    busy_cnt = 0;
    do_load(32'd0, 16'd0, 16'd3, e0);
    exp_q.push_back(e0 + 600);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", busy); end
    checks++; if (rem_usec !== 16'd3) begin errors++; $display("FAIL basic_usec_load got=%0d want=3", rem_usec); end
    wait_cyc(e0 + 199);
    checks++; if (rem_usec !== 16'd3) begin errors++; $display("FAIL basic_usec_199 got=%0d want=3", rem_usec); end
    wait_cyc(e0 + 200);
    checks++; if (rem_usec !== 16'd2) begin errors++; $display("FAIL basic_usec_200 got=%0d want=2", rem_usec); end
    wait_cyc(e0 + 400);
    checks++; if (rem_usec !== 16'd1) begin errors++; $display("FAIL basic_usec_400 got=%0d want=1", rem_usec); end
    wait_expired(1000, found);
    checks++;
    if (!found) begin
      errors++; $display("FAIL basic_expire_timeout got=none want=pulse");
    end else begin
      want = exp_q.pop_front(); popped++;
      checks++; if (cyc !== want) begin errors++; $display("FAIL basic_expire_cycle got=%0d want=%0d", cyc, want); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b want=0", busy); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_end got=%b want=1", load_ready); end
      checks++; if ({rem_sec, rem_msec, rem_usec} !== 64'd0) begin errors++;
        $display("FAIL basic_rem_end got=%0d/%0d/%0d want=0/0/0", rem_sec, rem_msec, rem_usec); end
      checks++; if (busy_cnt !== 600) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=600", busy_cnt); end
      @(negedge clk_200mhz);
      checks++; if (expired !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b want=0", expired); end
    end
  endtask

  task automatic test_one_sec();
    int e0;
    do_load(32'd1, 16'd0, 16'd0, e0);
    checks++; if ({rem_sec, rem_msec, rem_usec} !== {32'd1, 16'd0, 16'd0}) begin errors++;
      $display("FAIL sec_load got=%0d/%0d/%0d want=1/0/0", rem_sec, rem_msec, rem_usec); end
    wait_cyc(e0 + 200);
    checks++; if ({rem_sec, rem_msec, rem_usec} !== {32'd0, 16'd999, 16'd999}) begin errors++;
      $display("FAIL sec_borrow got=%0d/%0d/%0d want=0/999/999", rem_sec, rem_msec, rem_usec); end
    wait_cyc(e0 + 400);
    checks++; if ({rem_sec, rem_msec, rem_usec} !== {32'd0, 16'd999, 16'd998}) begin errors++;
      $display("FAIL sec_tick2 got=%0d/%0d/%0d want=0/999/998", rem_sec, rem_msec, rem_usec); end
    cancel = 1'b1;
    @(negedge clk_200mhz);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sec_cancel_busy got=%b want=0", busy); end
  endtask

  task automatic test_zero();
    int e0;
    int want;
    busy_cnt = 0;
    do_load(32'd0, 16'd0, 16'd0, e0);
    exp_q.push_back(e0);
    checks++;
    if (expired !== 1'b1) begin
      errors++; $display("FAIL zero_expired got=%b want=1", expired);
    end else begin
      want = exp_q.pop_front(); popped++;
      checks++; if (cyc !== want) begin errors++; $display("FAIL zero_expire_cycle got=%0d want=%0d", cyc, want); end
    end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b want=1", load_ready); end
    @(negedge clk_200mhz);
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL zero_pulse_width got=%b want=0", expired); end
    repeat (3) @(negedge clk_200mhz);
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL zero_busy_cycles got=%0d want=0", busy_cnt); end
  endtask

  task automatic test_cancel();
    int e0;
    int base;
    do_load(32'd0, 16'd0, 16'd5, e0);
    wait_cyc(e0 + 449);
    base = exp_cnt;
    cancel = 1'b1;
    @(negedge clk_200mhz);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b want=0", busy); end
    checks++; if ({rem_sec, rem_msec, rem_usec} !== 64'd0) begin errors++;
      $display("FAIL cancel_rem got=%0d/%0d/%0d want=0/0/0", rem_sec, rem_msec, rem_usec); end
    wait_cyc(cyc + 1200);
    checks++; if (exp_cnt !== base) begin errors++; $display("FAIL cancel_no_expiry got=%0d want=%0d", exp_cnt, base); end
    // Cancel on the same edge as the final tick.
    do_load(32'd0, 16'd0, 16'd5, e0);
    wait_cyc(e0 + 999);
    checks++; if (rem_usec !== 16'd1) begin errors++; $display("FAIL cancel_last_pre got=%0d want=1", rem_usec); end
    base = exp_cnt;
    cancel = 1'b1;
    @(negedge clk_200mhz);
    cancel = 1'b0;
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL cancel_last_expired got=%b want=0", expired); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_last_busy got=%b want=0", busy); end
    checks++; if ({rem_sec, rem_msec, rem_usec} !== 64'd0) begin errors++;
      $display("FAIL cancel_last_rem got=%0d/%0d/%0d want=0/0/0", rem_sec, rem_msec, rem_usec); end
    wait_cyc(cyc + 300);
    checks++; if (exp_cnt !== base) begin errors++; $display("FAIL cancel_last_no_expiry got=%0d want=%0d", exp_cnt, base); end
  endtask

  task automatic test_clamp();
    int e0;
    do_load(32'd0, 16'd1500, 16'd2000, e0);
    checks++; if ({rem_sec, rem_msec, rem_usec} !== {32'd0, 16'd999, 16'd999}) begin errors++;
      $display("FAIL clamp_load got=%0d/%0d/%0d want=0/999/999", rem_sec, rem_msec, rem_usec); end
    load_usec  = 16'd7;
    load_msec  = 16'd0;
    load_valid = 1'b1;
    wait_cyc(e0 + 200);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL clamp_ready_run got=%b want=0", load_ready); end
    checks++; if ({rem_msec, rem_usec} !== {16'd999, 16'd998}) begin errors++;
      $display("FAIL clamp_no_reload got=%0d/%0d want=999/998", rem_msec, rem_usec); end
    load_valid = 1'b0;
    cancel = 1'b1;
    @(negedge clk_200mhz);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clamp_cancel_busy got=%b want=0", busy); end
  endtask

`ifndef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_back_to_back();
    int e0;
    int e1;
    int want;
    bit found;
    do_load(32'd0, 16'd0, 16'd2, e0);
    exp_q.push_back(e0 + 400);
    wait_expired(600, found);
    checks++;
    if (!found) begin
      errors++; $display("FAIL b2b_first_timeout got=none want=pulse");
    end else begin
      want = exp_q.pop_front(); popped++;
      checks++; if (cyc !== want) begin errors++; $display("FAIL b2b_first_cycle got=%0d want=%0d", cyc, want); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_expired got=%b want=1", load_ready); end
      load_sec = 32'd0; load_msec = 16'd0; load_usec = 16'd1;
      load_valid = 1'b1;
      e1 = cyc + 1;
      exp_q.push_back(e1 + 200);
      @(negedge clk_200mhz);
      load_valid = 1'b0;
      checks++; if (busy !== 1'b1 || rem_usec !== 16'd1) begin errors++;
        $display("FAIL b2b_second_accept got=busy%b/usec%0d want=busy1/usec1", busy, rem_usec); end
      wait_expired(400, found);
      checks++;
      if (!found) begin
        errors++; $display("FAIL b2b_second_timeout got=none want=pulse");
      end else begin
        want = exp_q.pop_front(); popped++;
        checks++; if (cyc !== want) begin errors++; $display("FAIL b2b_second_cycle got=%0d want=%0d", cyc, want); end
      end
    end
  endtask
`else
  task automatic test_auto_reload();
    int e0;
    int want;
    int base;
    bit found;
    do_load(32'd0, 16'd0, 16'd2, e0);
    for (int k = 1; k <= 3; k++) exp_q.push_back(e0 + 400 * k);
    for (int k = 1; k <= 3; k++) begin
      wait_expired(600, found);
      checks++;
      if (!found) begin
        errors++; $display("FAIL auto_timeout_%0d got=none want=pulse", k);
        break;
      end
      want = exp_q.pop_front(); popped++;
      checks++; if (cyc !== want) begin errors++; $display("FAIL auto_cycle_%0d got=%0d want=%0d", k, cyc, want); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL auto_busy_%0d got=%b want=1", k, busy); end
      checks++; if (rem_usec !== 16'd2) begin errors++; $display("FAIL auto_reload_%0d got=%0d want=2", k, rem_usec); end
    end
    cancel = 1'b1;
    @(negedge clk_200mhz);
    cancel = 1'b0;
    base = exp_cnt;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL auto_cancel_busy got=%b want=0", busy); end
    wait_cyc(cyc + 1000);
    checks++; if (exp_cnt !== base) begin errors++; $display("FAIL auto_cancel_no_expiry got=%0d want=%0d", exp_cnt, base); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_one_sec();
    test_cancel();
    test_clamp();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    test_basic();
    test_back_to_back();
`else
    test_auto_reload();
`endif
    repeat (5) @(negedge clk_200mhz);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    checks++; if (exp_cnt !== popped) begin errors++; $display("FAIL expiry_total got=%0d want=%0d", exp_cnt, popped); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
